// File: rtl/i2c_slave.sv
// I2C register-file responder: 7-bit addressed, byte writes with auto-increment,
// current/random reads with ACK-driven auto-increment, open-drain SDA.
module i2c_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] RegAddr,
  output logic [7:0] RegWrData,
  output logic       RegWrEna,
  input  logic [7:0] RegRdData,
  output logic       Busy,
  output logic [3:0] o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEV_ADDR  = 4'd1,
    S_DEV_ACK   = 4'd2,
    S_REG_ADDR  = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WR_DATA   = 4'd5,
    S_WR_ACK    = 4'd6,
    S_RD_DATA   = 4'd7,
    S_RD_ACK    = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  state_t      r_state;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic        r_rw;
  logic        r_ack_phase;
  logic        r_sda_low;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_wr_data;
  logic        r_wr_ena;
  logic        r_busy;
  logic        r_inc_pending;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0]  w_rx_byte;

  // Synchronizers reset high so an idle bus produces no spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_last_bit = (r_bit_cnt == 4'd7);
  assign w_rx_byte  = {r_shift, r_sda_s2};

  // Only 7 bits are stored: on reads bit 7 goes straight onto the bus at load time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 7'd0;
      r_rw          <= 1'b0;
      r_ack_phase   <= 1'b0;
      r_sda_low     <= 1'b0;
      r_reg_addr    <= 8'h00;
      r_wr_data     <= 8'h00;
      r_wr_ena      <= 1'b0;
      r_busy        <= 1'b0;
      r_inc_pending <= 1'b0;
    end else begin
      r_wr_ena <= 1'b0;
      if (r_inc_pending) begin
        r_reg_addr    <= r_reg_addr + 8'd1;
        r_inc_pending <= 1'b0;
      end
      if (w_start) begin
        r_state     <= S_DEV_ADDR;
        r_bit_cnt   <= 4'd0;
        r_ack_phase <= 1'b0;
        r_sda_low   <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= 4'd0;
        r_ack_phase <= 1'b0;
        r_sda_low   <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[5:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
                if (r_state == S_DEV_ADDR) begin
                  r_rw <= r_sda_s2;
                  if (w_rx_byte[7:1] == DEVICE_ADDR) begin
                    r_state <= S_DEV_ACK;
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= S_WAIT_STOP;
                    r_busy  <= 1'b0;
                  end
                end else if (r_state == S_REG_ADDR) begin
                  r_reg_addr <= w_rx_byte;
                  r_state    <= S_REG_ACK;
                end else begin
                  r_wr_data     <= w_rx_byte;
                  r_wr_ena      <= 1'b1;
                  r_inc_pending <= 1'b1;
                  r_state       <= S_WR_ACK;
                end
              end
            end
          end
          // First scl fall asserts ACK, second releases it and starts the next byte.
          S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_low   <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_sda_low   <= 1'b0;
                r_bit_cnt   <= 4'd0;
                if (r_state == S_DEV_ACK && r_rw) begin
                  r_state   <= S_RD_DATA;
                  r_shift   <= RegRdData[6:0];
                  r_sda_low <= ~RegRdData[7];
                end else if (r_state == S_DEV_ACK) begin
                  r_state <= S_REG_ADDR;
                end else begin
                  r_state <= S_WR_DATA;
                end
              end
            end
          end
          S_RD_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_low   <= 1'b0;
                r_bit_cnt   <= 4'd0;
                r_ack_phase <= 1'b0;
                r_state     <= S_RD_ACK;
              end else begin
                r_sda_low <= ~r_shift[6];
                r_shift   <= {r_shift[5:0], 1'b1};
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (r_sda_s2) begin
                r_state <= S_WAIT_STOP;
              end else begin
                r_ack_phase <= 1'b1;
                r_reg_addr  <= r_reg_addr + 8'd1;
              end
            end else if (w_scl_fall && r_ack_phase) begin
              r_ack_phase <= 1'b0;
              r_bit_cnt   <= 4'd0;
              r_state     <= S_RD_DATA;
              r_shift     <= RegRdData[6:0];
              r_sda_low   <= ~RegRdData[7];
            end
          end
          default: begin
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda         = r_sda_low ? 1'b0 : 1'bz;
  assign RegAddr     = r_reg_addr;
  assign RegWrData   = r_wr_data;
  assign RegWrEna    = r_wr_ena;
  assign Busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged bus master, pulled-up SDA, strobe scoreboard.
module tb_i2c_slave;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_DEV_ACK = 4'd2;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       m_sda_low;
  wire        sda_bus;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_ena;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic [3:0] dbg_state;

  logic [7:0]  mem [256];
  logic [15:0] exp_q[$];
  int          half;
  int          n_checks;
  int          n_fails;
  int          strobe_cnt;
  int          slave_pulls;
  logic        busy_seen;

  pullup (sda_bus);
  assign sda_bus     = m_sda_low ? 1'b0 : 1'bz;
  assign reg_rd_data = mem[reg_addr];

  i2c_slave #(.DEVICE_ADDR(7'h50)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl_m),
    .sda        (sda_bus),
    .RegAddr    (reg_addr),
    .RegWrData  (reg_wr_data),
    .RegWrEna   (reg_wr_ena),
    .RegRdData  (reg_rd_data),
    .Busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && reg_wr_ena) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_strobe", {16'd0, reg_addr, reg_wr_data}, 32'd0);
      else check_eq("wr_strobe", {16'd0, reg_addr, reg_wr_data}, {16'd0, exp_q.pop_front()});
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (sda_bus === 1'b0 && !m_sda_low) slave_pulls++;
      if (busy) busy_seen = 1'b1;
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clks(half / 2);
    scl_m = 1'b1;     wait_clks(half);
    m_sda_low = 1'b1; wait_clks(half);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(half / 2); m_sda_low = 1'b1; wait_clks(half - half / 2);
    scl_m = 1'b1;        wait_clks(half);
    m_sda_low = 1'b0;    wait_clks(half);
  endtask

  task automatic send_bit(input logic b);
    wait_clks(half / 2); m_sda_low = ~b; wait_clks(half - half / 2);
    scl_m = 1'b1; wait_clks(half);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clks(half / 2); m_sda_low = 1'b0; wait_clks(half - half / 2);
    scl_m = 1'b1; wait_clks(half / 2);
    b = sda_bus;  wait_clks(half - half / 2);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic do_reset();
    rst = 1'b1; scl_m = 1'b1; m_sda_low = 1'b0;
    wait_clks(5);
    check_eq("rst_regaddr", {24'd0, reg_addr}, 32'h00);
    check_eq("rst_wrdata", {24'd0, reg_wr_data}, 32'h00);
    check_eq("rst_wrena", {31'd0, reg_wr_ena}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sda", {31'd0, sda_bus}, 32'd1);
    check_eq("rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    rst = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_write();
    logic ack;
    strobe_cnt = 0;
    exp_q.push_back({8'h10, 8'hA5});
    i2c_start();
    write_byte(8'hA0, ack); check_eq("wr_dev_ack", {31'd0, ack}, 32'd1);
    check_eq("wr_busy_mid", {31'd0, busy}, 32'd1);
    write_byte(8'h10, ack); check_eq("wr_reg_ack", {31'd0, ack}, 32'd1);
    write_byte(8'hA5, ack); check_eq("wr_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_eq("wr_strobe_cnt", strobe_cnt, 32'd1);
    check_eq("wr_regaddr_after", {24'd0, reg_addr}, 32'h11);
    check_eq("wr_wrdata_after", {24'd0, reg_wr_data}, 32'hA5);
    check_eq("wr_busy_after", {31'd0, busy}, 32'd0);
    check_eq("wr_state_after", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check_eq("wr_q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic test_random_read();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack); check_eq("rr_dev_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h10, ack); check_eq("rr_reg_ack", {31'd0, ack}, 32'd1);
    i2c_start();
    write_byte(8'hA1, ack); check_eq("rr_dev_rd_ack", {31'd0, ack}, 32'd1);
    check_eq("rr_busy_mid", {31'd0, busy}, 32'd1);
    read_byte(1'b1, d);
    check_eq("rr_data", {24'd0, d}, 32'h3C);
    i2c_stop();
    check_eq("rr_regaddr_after", {24'd0, reg_addr}, 32'h10);
    check_eq("rr_busy_after", {31'd0, busy}, 32'd0);
    check_eq("rr_state_after", {28'd0, dbg_state}, {28'd0, ST_IDLE});
  endtask

  task automatic test_burst_read();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA1, ack); check_eq("br_dev_ack", {31'd0, ack}, 32'd1);
    read_byte(1'b0, d); check_eq("br_data0", {24'd0, d}, 32'h3C);
    read_byte(1'b1, d); check_eq("br_data1", {24'd0, d}, 32'h5A);
    i2c_stop();
    check_eq("br_regaddr_after", {24'd0, reg_addr}, 32'h11);
  endtask

  task automatic test_wrong_addr();
    logic ack;
    strobe_cnt  = 0;
    slave_pulls = 0;
    busy_seen   = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check_eq("wa_dev_nack", {31'd0, ack}, 32'd0);
    write_byte(8'h10, ack); check_eq("wa_reg_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check_eq("wa_slave_pulls", slave_pulls, 32'd0);
    check_eq("wa_busy_seen", {31'd0, busy_seen}, 32'd0);
    check_eq("wa_strobe_cnt", strobe_cnt, 32'd0);
  endtask

  task automatic test_wrap();
    logic ack;
    strobe_cnt = 0;
    exp_q.push_back({8'hFF, 8'h11});
    exp_q.push_back({8'h00, 8'h22});
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); check_eq("wrap_d0_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h22, ack); check_eq("wrap_d1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check_eq("wrap_strobe_cnt", strobe_cnt, 32'd2);
    check_eq("wrap_regaddr_after", {24'd0, reg_addr}, 32'h01);
    check_eq("wrap_q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic test_abort();
    logic ack;
    strobe_cnt = 0;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack); check_eq("ab_reg_ack", {31'd0, ack}, 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    check_eq("ab_strobe_cnt", strobe_cnt, 32'd0);
    check_eq("ab_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check_eq("ab_busy", {31'd0, busy}, 32'd0);
    check_eq("ab_regaddr", {24'd0, reg_addr}, 32'h20);
  endtask

  task automatic test_rst_in_ack();
    logic [7:0] a;
    logic       seen;
    a = 8'hA0;
    seen = 1'b0;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    m_sda_low = 1'b0;
    for (int i = 0; i < 2 * half + 8 && !seen; i++) begin
      wait_clks(1);
      if (sda_bus === 1'b0) seen = 1'b1;
    end
    check_eq("ra_ack_driven", {31'd0, seen}, 32'd1);
    check_eq("ra_state_dev_ack", {28'd0, dbg_state}, {28'd0, ST_DEV_ACK});
    rst = 1'b1;
    wait_clks(1);
    check_eq("ra_sda_released", {31'd0, sda_bus}, 32'd1);
    check_eq("ra_state_idle", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    check_eq("ra_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_clks(4);
    slave_pulls = 0;
    busy_seen   = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    send_bit(1'b1);
    check_eq("ra_no_start_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    i2c_stop();
    check_eq("ra_no_start_pulls", slave_pulls, 32'd0);
    check_eq("ra_no_start_busy", {31'd0, busy_seen}, 32'd0);
    check_eq("ra_regaddr", {24'd0, reg_addr}, 32'h00);
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    strobe_cnt  = 0;
    slave_pulls = 0;
    busy_seen   = 1'b0;
    rst         = 1'b1;
    scl_m       = 1'b1;
    m_sda_low   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'h5A;

    half = 250;
    do_reset();
    test_write();
    test_random_read();

    half = 8;
    do_reset();
    test_write();
    test_random_read();
    test_burst_read();
    test_wrong_addr();
    test_wrap();
    test_abort();
    test_rst_in_ack();

    wait_clks(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h50, the 7-bit I2C address this responder answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port scl  input  1  I2C serial clock driven by the bus master.
REQ-005 SHALL have port sda  inout  1  I2C data line: driven 0 when pulling low, else high-Z (open-drain).
REQ-006 SHALL have port RegAddr  output  8  current register pointer.
REQ-007 SHALL have port RegWrData  output  8  last received write byte.
REQ-008 SHALL have port RegWrEna  output  1  one-clk strobe; RegWrData is written at RegAddr.
REQ-009 SHALL have port RegRdData  input  8  combinational register-file read data at RegAddr.
REQ-010 SHALL have port Busy  output  1  high from an addressed START until STOP or abort.

Function
REQ-011 SHALL pass scl and sda through 2-FF synchronizers, then edge-detect on the synchronized values; events are recognised 3 clk after the pin change.
REQ-012 SHALL detect START as sda falling while scl high, and STOP as sda rising while scl high, in every state.
REQ-013 SHALL sample received bits on scl rising, MSB first; SHALL change its sda drive only on scl falling.
REQ-014 SHALL implement states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 IDLE: sda released and Busy=0; START -> DEV_ADDR with bit counter cleared.
REQ-016 DEV_ADDR: after 8 bits, if addr[7:1]==DEVICE_ADDR -> DEV_ACK and Busy=1, else -> WAIT_STOP with sda released and no ACK.
REQ-017 DEV_ACK: drive sda=0 from the scl falling edge after bit 8 until the next scl falling; then R/W=0 -> REG_ADDR, R/W=1 -> RD_DATA.
REQ-018 REG_ADDR: after 8 bits, load RegAddr -> REG_ACK (ACK as in REQ-017) -> WR_DATA.
REQ-019 WR_DATA: after 8 bits, RegWrData=byte, RegWrEna=1 for exactly one clk -> WR_ACK (ACK) -> WR_DATA; RegAddr increments by 1 on the clk after the strobe, wrapping 8'hFF->8'h00.
REQ-020 RD_DATA: capture RegRdData into a shift register on entry; drive bit 7 at entry (from the DEV_ACK/RD_ACK scl falling), then the next bit each scl falling; drive 0 as sda=0, drive 1 as high-Z.
REQ-021 RD_DATA after 8 bits -> RD_ACK with sda released; sample master bit on scl rising: 0 (ACK) -> RegAddr+1 (wrapping), then RD_DATA; 1 (NACK) -> WAIT_STOP.
REQ-022 Repeated START in any non-IDLE state SHALL abort the current byte, release sda, and go to DEV_ADDR; RegAddr is retained.
REQ-023 STOP in any state SHALL go to IDLE, release sda, and clear Busy; a partial write byte SHALL NOT produce RegWrEna.
REQ-024 WAIT_STOP: sda released; exits only on START (-> DEV_ADDR) or STOP (-> IDLE).
REQ-025 SHALL operate correctly for any scl high and low phase of at least 8 clk, including 250-clk phases.
REQ-026 START/STOP detection SHALL take priority over a data-bit sample in the same clk.

Reset
REQ-027 While rst=1: state=IDLE, sda released (high-Z), RegAddr=8'h00, RegWrData=8'h00, RegWrEna=0, Busy=0, bit counter=0, synchronizers=1.
REQ-028 rst asserted mid-transaction SHALL release sda on the next clk edge; after rst, the block SHALL ignore bus activity until the next START.

Verification
REQ-029 Write: START, 0xA0, 0x10, 0xA5, STOP -> ACK on all 3 bytes; single RegWrEna with RegAddr=0x10 and RegWrData=0xA5; RegAddr=0x11 after.
REQ-030 Random read: START, 0xA0, 0x10, repeated START, 0xA1, master NACK, STOP, RegRdData=0x3C at 0x10 -> sda bits 0,0,1,1,1,1,0,0; Busy=0 after STOP.
REQ-031 Wrong address: START, 0xA2, ... -> sda never pulled low; RegWrEna never asserted; Busy stays 0.
REQ-032 Burst: write 0xFF then data 0x11, 0x22 -> strobes at RegAddr 0xFF then 0x00 (wrap).
REQ-033 Abort: STOP after 4 data bits -> no RegWrEna, state IDLE; rst during DEV_ACK -> sda high-Z next clk.
REQ-034 Bench: pull-up on sda, scl with 250-clk phases; also run with 8-clk phases.
